bk_sum_accumulator: RTL

- Downstream stage of the 4-bit Brent-Kung adder; consumes its 5-bit sum (uo_out[4:0]) once per accepted handshake.
- Accumulates a frame of N sums into a wider register, then presents total, sample count and overflow flag on a valid/ready output port.
- Sits between the combinational adder and the chip output mux.
- Gives the adder a sequential consumer for multi-cycle checking on silicon.

---
 rtl/bk_pkg.sv | 22 ++
 rtl/bk_sat_add.sv | 33 +++
 rtl/bk_sum_accumulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bk_pkg
// Description : Shared types and default widths for the Brent-Kung sum
//               accumulator slice.
// Revision    : 1.0 - initial release
// ============================================================================
package bk_pkg;

  localparam int BK_OPERAND_W = 4;
  localparam int BK_SUM_W     = BK_OPERAND_W + 1;
  localparam int BK_ACC_W     = 12;
  localparam int BK_CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bk_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : bk_sat_add
// Description : Combinational accumulator + sample adder with carry out.
//               Macro BK_ACC_SATURATE_EN selects clamp-to-max on carry.
// Revision    : 1.0 - initial release
// ============================================================================
module bk_sat_add
  import bk_pkg::*;
#(
  parameter int SUM_W = BK_SUM_W,
  parameter int ACC_W = BK_ACC_W
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [SUM_W-1:0] sum_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, acc_i} + (ACC_W+1)'(sum_i);
  assign carry_o = w_full[ACC_W];

`ifdef BK_ACC_SATURATE_EN
  // Once clamped, every further add carries again, so the value stays pinned.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign sum_o = w_full[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/bk_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : bk_sum_accumulator
// Description : Accumulates a frame of adder sums and presents total, count
//               and sticky overflow on a valid/ready port.
//               Optional macro: BK_ACC_SATURATE_EN (saturating accumulate).
// Revision    : 1.0 - initial release
// ============================================================================
module bk_sum_accumulator
  import bk_pkg::*;
#(
  parameter int SUM_W = BK_SUM_W,
  parameter int ACC_W = BK_ACC_W,
  parameter int CNT_W = BK_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q;

  logic             w_accept;
  logic             w_load_out;
  logic [ACC_W-1:0] w_add_sum;
  logic             w_add_carry;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_first_len;

  assign in_ready    = (state_q != HOLD);
  assign w_accept    = in_valid && in_ready;
  assign w_cnt_inc   = cnt_q + CNT_W'(1);
  assign w_first_len = (frame_len == '0) ? CNT_W'(1) : frame_len;

  bk_sat_add #(
    .SUM_W (SUM_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .sum_i   (in_sum),
    .sum_o   (w_add_sum),
    .carry_o (w_add_carry)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          acc_d   = ACC_W'(in_sum);
          cnt_d   = CNT_W'(1);
          len_d   = w_first_len;
          ovf_d   = 1'b0;
          state_d = (w_first_len == CNT_W'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          acc_d = w_add_sum;
          ovf_d = ovf_q | w_add_carry;
          cnt_d = w_cnt_inc;
        end
        // A flush coinciding with a sample closes the frame with that sample included.
        if ((w_accept && (w_cnt_inc == len_q)) || flush) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_load_out = (state_q != HOLD) && (state_d == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      if (w_load_out) begin
        out_acc_q   <= acc_d;
        out_count_q <= cnt_d;
        out_ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire
